rtp_udp_packetizer: RTL and testbench
=====================================

Name: rtp_udp_packetizer

Overview:
- Parametrised next-generation IPv4/UDP/RTP packetizer.
- Accepts a packet request (payload length, RTP timestamp, marker) and computes the IPv4 header checksum.
- Emits the 40-byte IPv4+UDP+RTP header, then packs IN_W-bit payload beats MSB-first into bytes.
- Byte stream uses a ready/valid handshake with backpressure and a last flag. Sits between the sample/bit source and the Ethernet framer.

Parameters:
IN_W, 1, payload input beat width in bits; legal 1, 2, 4, 8
MAX_PAYLOAD, 1460, largest accepted payload in bytes
SRC_IP, 32'h0A000001, IPv4 source address
DST_IP, 32'h0A2A00FF, IPv4 destination address
SRC_PORT, 16'd2000, UDP source port
DST_PORT, 16'd2000, UDP destination port
TTL, 8'd7, IPv4 time-to-live
PT, 7'h1F, RTP payload type
SSRC, 32'd123456, RTP synchronisation source
SEQ_INIT, 16'h0000, RTP sequence number after reset

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
start_in  input  1  one-cycle packet request, sampled only in IDLE
payload_len_in  input  11  payload length in bytes
rtp_timestamp_in  input  32  RTP timestamp, latched at start
rtp_marker_in  input  1  RTP marker bit, latched at start
in_data  input  IN_W  payload beat; MSB is sent first
in_valid  input  1  payload beat valid
in_ready  output  1  payload beat accepted when in_valid && in_ready
out_data  output  8  packet byte
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts byte
out_last  output  1  final byte of packet, qualified by out_valid
busy_out  output  1  high in every state except IDLE
pkt_done_out  output  1  one-cycle pulse after the last byte handshake
err_out  output  1  one-cycle pulse on a rejected start

Behaviour:
- Clock and reset: single clock clk_in. rst_in is synchronous and active-high.
- Reset values: state IDLE; out_valid, out_last, in_ready, busy_out, pkt_done_out, err_out all 0; out_data 0; seq = SEQ_INIT. Reset mid-packet aborts immediately; no partial byte is emitted.
- IDLE:
  - start_in with payload_len_in > MAX_PAYLOAD: err_out pulses next cycle, state stays IDLE.
  - Otherwise latch length, timestamp and marker; go to CSUM.
- CSUM (exactly 10 cycles):
  - Accumulate in a 17-bit one's-complement sum, folding the carry every cycle, the words 0x4500, total_len, 0x0000, 0x4000, {TTL,8'h11}, SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0], plus 0x0000 for the checksum field.
  - total_len = 40 + L; udp_len = 20 + L, where L is the payload length.
  - Checksum is the bitwise NOT of the folded sum. Go to HEADER.
- HEADER (40 bytes, MSB first):
  - IPv4: ver 4, IHL 5, TOS 0, total_len, ID 0, flags DF, frag 0, TTL, proto 17, checksum, src, dst.
  - UDP: src port, dst port, udp_len, checksum 0.
  - RTP: {2'b10, 0, 0, 4'b0}, {marker, PT}, seq, timestamp, SSRC.
  - Byte index advances only on out_valid && out_ready.
  - The first header byte is valid on the cycle after CSUM ends, i.e. 11 cycles after start_in.
  - After the 40th handshake: go to PAYLOAD, or to DONE if L = 0. When L = 0, the 40th byte carries out_last.
- PAYLOAD:
  - Beats are shifted into an 8-bit assembly register MSB-first; 8/IN_W beats make one byte.
  - in_ready = 1 while bytes remain, except when a completed byte is held (out_valid && !out_ready).
  - A completed byte moves to out_data/out_valid on the cycle after its final beat is accepted; out_last is high for byte L.
  - in_ready drops the cycle after the final beat of byte L is accepted; excess beats are not consumed.
- DONE: pkt_done_out pulses, seq increments modulo 2^16 (0xFFFF wraps to 0x0000), return to IDLE.
- Output handshake:
  - out_data and out_last hold stable while out_valid && !out_ready.
  - out_valid never deasserts without a handshake, except on reset.
- Concurrency: start_in outside IDLE is ignored, with no err_out. A start in the same cycle as the DONE-to-IDLE transition is ignored.

Test Plan:
- Checksum and header: IN_W=8, L=100, TTL=7, default IPs, out_ready=1 -> bytes 0..3 = 45 00 00 8C, checksum bytes 10..11 = 5E 38, UDP length bytes 24..25 = 00 78, byte 29 = 0x9F when marker=1, 140 bytes total, out_last on byte 140, pkt_done_out one cycle after.
- Bit packing: IN_W=1, L=2, serial bits 1,0,1,0,0,1,0,1 then 0xFF's bits -> payload bytes 0xA5, 0xFF; in_ready low after the 16th accepted bit.
- Backpressure: out_ready toggled randomly with IN_W=4 -> byte stream identical to the out_ready=1 run; out_data stable whenever stalled; no beats lost.
- Sequence: SEQ_INIT=16'hFFFF, send two packets -> RTP seq fields FFFF then 0000.
- Errors and zero length: L=1461 -> err_out pulse, busy_out stays 0. L=0 -> 40 bytes, out_last on byte 40, UDP length 0x0014.
- Reset: assert rst_in mid-payload -> out_valid, in_ready and busy_out are 0 the next cycle; the next packet carries seq = SEQ_INIT.

Source files
------------

// File: rtl/rtp_udp_packetizer.sv
// IPv4/UDP/RTP packetizer: computes the IPv4 header checksum, emits the 40-byte
// header and then packs IN_W-bit payload beats MSB-first into a ready/valid byte stream.
module rtp_udp_packetizer #(
    parameter int          IN_W        = 1,
    parameter int          MAX_PAYLOAD = 1460,
    parameter logic [31:0] SRC_IP      = 32'h0A000001,
    parameter logic [31:0] DST_IP      = 32'h0A2A00FF,
    parameter logic [15:0] SRC_PORT    = 16'd2000,
    parameter logic [15:0] DST_PORT    = 16'd2000,
    parameter logic [7:0]  TTL         = 8'd7,
    parameter logic [6:0]  PT          = 7'h1F,
    parameter logic [31:0] SSRC        = 32'd123456,
    parameter logic [15:0] SEQ_INIT    = 16'h0000
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            start_in,
    input  logic [10:0]     payload_len_in,
    input  logic [31:0]     rtp_timestamp_in,
    input  logic            rtp_marker_in,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [7:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy_out,
    output logic            pkt_done_out,
    output logic            err_out
);

    localparam int HDR_BYTES  = 40;
    localparam int CSUM_WORDS = 10;
    localparam int BEATS      = 8 / IN_W;

    // Elaboration guard: an illegal beat width instantiates a module that does not exist.
    generate
        if (!(IN_W == 1 || IN_W == 2 || IN_W == 4 || IN_W == 8)) begin : g_bad_in_w
            illegal_in_w_parameter u_illegal_in_w ();
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSUM,
        S_HEADER,
        S_PAYLOAD,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [16:0] sum_q, sum_d;
    logic [10:0] len_q, len_d;
    logic [31:0] ts_q, ts_d;
    logic        marker_q, marker_d;
    logic [15:0] seq_q, seq_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [7:0]  asm_q, asm_d;
    logic [2:0]  beat_q, beat_d;
    logic [10:0] bytes_q, bytes_d;
    logic        err_q, err_d;

    logic [15:0] total_len;
    logic [15:0] udp_len;
    logic [15:0] csum;
    logic [15:0] csum_word;
    logic [16:0] csum_add;
    logic [319:0] hdr_vec;
    logic [7:0]  hdr_byte [HDR_BYTES];
    logic [7:0]  hdr_cur;
    logic        out_hs;
    logic        beat_acc;
    logic        byte_done;
    logic [7+IN_W:0] shift_w;

    assign total_len = 16'(len_q) + 16'd40;
    assign udp_len   = 16'(len_q) + 16'd20;
    // A carry may still be pending in bit 16 after the last add; fold it before inverting.
    assign csum      = ~(sum_q[15:0] + 16'(sum_q[16]));

    assign hdr_vec = {8'h45, 8'h00, total_len, 16'h0000, 16'h4000, TTL, 8'h11, csum,
                      SRC_IP, DST_IP,
                      SRC_PORT, DST_PORT, udp_len, 16'h0000,
                      8'h80, marker_q, PT, seq_q, ts_q, SSRC};

    genvar gi;
    generate
        for (gi = 0; gi < HDR_BYTES; gi++) begin : g_hdr
            assign hdr_byte[gi] = hdr_vec[319 - 8*gi -: 8];
        end
    endgenerate

    assign hdr_cur = (cnt_q < 6'(HDR_BYTES)) ? hdr_byte[cnt_q] : 8'h00;

    always_comb begin
        csum_word = 16'h0000;
        case (cnt_q)
            6'd0:    csum_word = 16'h4500;
            6'd1:    csum_word = total_len;
            6'd2:    csum_word = 16'h0000;
            6'd3:    csum_word = 16'h4000;
            6'd4:    csum_word = {TTL, 8'h11};
            6'd5:    csum_word = SRC_IP[31:16];
            6'd6:    csum_word = SRC_IP[15:0];
            6'd7:    csum_word = DST_IP[31:16];
            6'd8:    csum_word = DST_IP[15:0];
            default: csum_word = 16'h0000;
        endcase
    end

    assign csum_add  = {1'b0, sum_q[15:0]} + {16'h0000, sum_q[16]} + {1'b0, csum_word};

    assign out_hs    = out_valid_q && out_ready;
    assign in_ready  = (state_q == S_PAYLOAD) && (bytes_q != len_q)
                       && !(out_valid_q && !out_ready);
    assign beat_acc  = in_valid && in_ready;
    assign byte_done = beat_acc && (beat_q == 3'(BEATS - 1));
    assign shift_w   = {asm_q, in_data};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        len_d       = len_q;
        ts_d        = ts_q;
        marker_d    = marker_q;
        seq_d       = seq_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        asm_d       = asm_q;
        beat_d      = beat_q;
        bytes_d     = bytes_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    if (int'(payload_len_in) > MAX_PAYLOAD) begin
                        err_d = 1'b1;
                    end else begin
                        len_d    = payload_len_in;
                        ts_d     = rtp_timestamp_in;
                        marker_d = rtp_marker_in;
                        sum_d    = '0;
                        cnt_d    = '0;
                        asm_d    = '0;
                        beat_d   = '0;
                        bytes_d  = '0;
                        state_d  = S_CSUM;
                    end
                end
            end

            S_CSUM: begin
                sum_d = {1'b0, csum_add[15:0]} + {16'h0000, csum_add[16]};
                if (cnt_q == 6'(CSUM_WORDS - 1)) begin
                    // Byte 0 is a constant, so it can launch while the last word settles.
                    out_data_d  = hdr_byte[0];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    cnt_d       = 6'd1;
                    state_d     = S_HEADER;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

            S_HEADER: begin
                if (out_hs) begin
                    if (cnt_q == 6'(HDR_BYTES)) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = (len_q == 11'd0) ? S_DONE : S_PAYLOAD;
                    end else begin
                        out_data_d = hdr_cur;
                        out_last_d = (cnt_q == 6'(HDR_BYTES - 1)) && (len_q == 11'd0);
                        cnt_d      = cnt_q + 6'd1;
                    end
                end
            end

            S_PAYLOAD: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = S_DONE;
                    end
                end
                // A completed byte may replace one being handed off in the same cycle.
                if (beat_acc) begin
                    asm_d = shift_w[7:0];
                    if (byte_done) begin
                        beat_d      = '0;
                        out_data_d  = shift_w[7:0];
                        out_valid_d = 1'b1;
                        out_last_d  = ((bytes_q + 11'd1) == len_q);
                        bytes_d     = bytes_q + 11'd1;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end

            S_DONE: begin
                seq_d   = seq_q + 16'd1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sum_q       <= '0;
            len_q       <= '0;
            ts_q        <= '0;
            marker_q    <= 1'b0;
            seq_q       <= SEQ_INIT;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            asm_q       <= '0;
            beat_q      <= '0;
            bytes_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            len_q       <= len_d;
            ts_q        <= ts_d;
            marker_q    <= marker_d;
            seq_q       <= seq_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            asm_q       <= asm_d;
            beat_q      <= beat_d;
            bytes_q     <= bytes_d;
            err_q       <= err_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign busy_out     = (state_q != S_IDLE);
    assign pkt_done_out = (state_q == S_DONE);
    assign err_out      = err_q;

endmodule

// File: tb/tb_rtp_udp_packetizer.sv
// Bench for rtp_udp_packetizer: three instances (IN_W 8, 1, 4; the last with SEQ_INIT FFFF)
// driven one at a time; expected bytes are queued at stimulus time and popped per handshake.
`timescale 1ns/1ps
module tb_rtp_udp_packetizer;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic [NDUT-1:0]           start_a;
    logic [NDUT-1:0][10:0]     len_a;
    logic [NDUT-1:0][31:0]     ts_a;
    logic [NDUT-1:0]           marker_a;
    logic [NDUT-1:0][7:0]      in_data_a;
    logic [NDUT-1:0]           in_valid_a;
    logic [NDUT-1:0]           in_ready_a;
    logic [NDUT-1:0][7:0]      out_data_a;
    logic [NDUT-1:0]           out_valid_a;
    logic [NDUT-1:0]           out_ready_a;
    logic [NDUT-1:0]           out_last_a;
    logic [NDUT-1:0]           busy_a;
    logic [NDUT-1:0]           done_a;
    logic [NDUT-1:0]           err_a;

    int          in_w_of     [NDUT] = '{8, 1, 4};
    logic [15:0] seq_init_of [NDUT] = '{16'h0000, 16'h0000, 16'hFFFF};
    logic [15:0] seq_exp     [NDUT];

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int          IW = (gi == 0) ? 8 : (gi == 1) ? 1 : 4;
            localparam logic [15:0] SI = (gi == 2) ? 16'hFFFF : 16'h0000;
            rtp_udp_packetizer #(.IN_W(IW), .SEQ_INIT(SI)) u_dut (
                .clk_in          (clk),
                .rst_in          (rst),
                .start_in        (start_a[gi]),
                .payload_len_in  (len_a[gi]),
                .rtp_timestamp_in(ts_a[gi]),
                .rtp_marker_in   (marker_a[gi]),
                .in_data         (in_data_a[gi][IW-1:0]),
                .in_valid        (in_valid_a[gi]),
                .in_ready        (in_ready_a[gi]),
                .out_data        (out_data_a[gi]),
                .out_valid       (out_valid_a[gi]),
                .out_ready       (out_ready_a[gi]),
                .out_last        (out_last_a[gi]),
                .busy_out        (busy_a[gi]),
                .pkt_done_out    (done_a[gi]),
                .err_out         (err_a[gi])
            );
        end
    endgenerate

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q  [$];
    logic [7:0] pay_q  [$];
    logic [7:0] beat_q [$];
    logic [7:0] rx_q   [$];
    logic [7:0] save_q [$];
    int first_n, last_n, done_n, nbytes;

    // Reference header built field by field; checksum by wide sum then end-around folding.
    function automatic void push_header(input int len, input logic mk,
                                        input logic [15:0] seq, input logic [31:0] ts);
        logic [15:0] tl, ul, ck;
        int s;
        tl = 16'(40 + len);
        ul = 16'(20 + len);
        s  = 32'h4500 + int'(tl) + 32'h4000 + 32'h0711 + 32'h0A00 + 32'h0001 + 32'h0A2A + 32'h00FF;
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        ck = ~s[15:0];
        exp_q.push_back(8'h45); exp_q.push_back(8'h00); exp_q.push_back(tl[15:8]); exp_q.push_back(tl[7:0]);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h40); exp_q.push_back(8'h00);
        exp_q.push_back(8'h07); exp_q.push_back(8'h11); exp_q.push_back(ck[15:8]); exp_q.push_back(ck[7:0]);
        exp_q.push_back(8'h0A); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back(8'h0A); exp_q.push_back(8'h2A); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h07); exp_q.push_back(8'hD0); exp_q.push_back(8'h07); exp_q.push_back(8'hD0);
        exp_q.push_back(ul[15:8]); exp_q.push_back(ul[7:0]); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h80); exp_q.push_back({mk, 7'h1F}); exp_q.push_back(seq[15:8]); exp_q.push_back(seq[7:0]);
        exp_q.push_back(ts[31:24]); exp_q.push_back(ts[23:16]); exp_q.push_back(ts[15:8]); exp_q.push_back(ts[7:0]);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'hE2); exp_q.push_back(8'h40);
    endfunction

    task automatic run_packet(input int k, input int len, input logic [31:0] ts,
                              input logic mk, input bit rnd_ready);
        int n, bi, w;
        logic held, hl, excess, got_done;
        logic [7:0] hd, e;
        w = in_w_of[k];
        exp_q.delete(); rx_q.delete(); beat_q.delete();
        push_header(len, mk, seq_exp[k], ts);
        for (int i = 0; i < pay_q.size(); i++) begin
            exp_q.push_back(pay_q[i]);
            for (int j = 0; j < 8 / w; j++)
                beat_q.push_back(8'((int'(pay_q[i]) >> (8 - w * (j + 1))) & ((1 << w) - 1)));
        end
        first_n = -1; last_n = -1; done_n = -1; nbytes = 0;
        held = 1'b0; hl = 1'b0; hd = 8'h00; excess = 1'b0; got_done = 1'b0; bi = 0;
        @(negedge clk);
        start_a[k] = 1'b1; len_a[k] = 11'(len); ts_a[k] = ts; marker_a[k] = mk;
        @(negedge clk);
        start_a[k] = 1'b0;
        n = 1;
        while (!got_done && n < 4000) begin
            out_ready_a[k] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid_a[k]  = 1'b1;
            in_data_a[k]   = (bi < beat_q.size()) ? beat_q[bi] : 8'($urandom);
            #1;
            if (held) begin
                n_cmp++;
                if (out_valid_a[k] !== 1'b1 || out_data_a[k] !== hd || out_last_a[k] !== hl) begin
                    n_bad++;
                    $display("FAIL stall_hold dut%0d cyc %0d: got v=%b d=%02h l=%b, need v=1 d=%02h l=%b",
                             k, n, out_valid_a[k], out_data_a[k], out_last_a[k], hd, hl);
                end
            end
            if (out_valid_a[k] === 1'b1 && first_n < 0) first_n = n;
            if (out_valid_a[k] === 1'b1 && out_ready_a[k] === 1'b1) begin
                rx_q.push_back(out_data_a[k]);
                nbytes++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_byte dut%0d: got %02h, need no byte", k, out_data_a[k]);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data_a[k] !== e || out_last_a[k] !== (exp_q.size() == 0)) begin
                        n_bad++;
                        $display("FAIL byte%0d dut%0d: got %02h last=%b, need %02h last=%b",
                                 nbytes - 1, k, out_data_a[k], out_last_a[k], e, exp_q.size() == 0);
                    end
                end
                if (out_last_a[k] === 1'b1) last_n = n;
            end
            held = out_valid_a[k] && !out_ready_a[k];
            hd   = out_data_a[k];
            hl   = out_last_a[k];
            if (in_valid_a[k] === 1'b1 && in_ready_a[k] === 1'b1) begin
                if (bi >= beat_q.size()) excess = 1'b1;
                bi++;
            end
            if (done_a[k] === 1'b1) begin
                got_done = 1'b1;
                done_n   = n;
            end
            @(negedge clk);
            n++;
        end
        in_valid_a[k]  = 1'b0;
        out_ready_a[k] = 1'b1;
        n_cmp++;
        if (!got_done || done_n != last_n + 1) begin
            n_bad++;
            $display("FAIL pkt_done dut%0d: got done cyc %0d, need last cyc+1 = %0d", k, done_n, last_n + 1);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_bytes dut%0d: got %0d bytes, need %0d", k, nbytes, nbytes + exp_q.size());
        end
        n_cmp++;
        if (excess || bi != beat_q.size()) begin
            n_bad++;
            $display("FAIL beats dut%0d: got %0d accepted, need %0d", k, bi, beat_q.size());
        end
        #1;
        n_cmp++;
        if (done_a[k] !== 1'b0 || busy_a[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after dut%0d: got done=%b busy=%b, need 0 0", k, done_a[k], busy_a[k]);
        end
        $display("pkt dut%0d len=%0d seq=%04h bytes=%0d first_valid=%0d done=%0d",
                 k, len, seq_exp[k], nbytes, first_n, done_n);
        seq_exp[k] = seq_exp[k] + 16'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = '0; len_a = '0; ts_a = '0; marker_a = '0;
        in_data_a = '0; in_valid_a = '0; out_ready_a = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NDUT; k++) seq_exp[k] = seq_init_of[k];
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            n_cmp++;
            if ({out_valid_a[k], out_last_a[k], in_ready_a[k], busy_a[k], done_a[k], err_a[k]} !== 6'b0
                || out_data_a[k] !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: got v=%b l=%b ir=%b b=%b d=%b e=%b data=%02h, need all 0",
                         k, out_valid_a[k], out_last_a[k], in_ready_a[k], busy_a[k], done_a[k], err_a[k], out_data_a[k]);
            end
        end
        $display("reset: outputs sampled");
    endtask

    task automatic check_rx(input string name, input int idx, input logic [7:0] need);
        n_cmp++;
        if (idx >= rx_q.size()) begin
            n_bad++;
            $display("FAIL %s: got no byte %0d, need %02h", name, idx, need);
        end else if (rx_q[idx] !== need) begin
            n_bad++;
            $display("FAIL %s: got %02h at byte %0d, need %02h", name, rx_q[idx], idx, need);
        end
    endtask

    task automatic test_header();
        pay_q.delete();
        for (int i = 0; i < 100; i++) pay_q.push_back(8'($urandom));
        run_packet(0, 100, 32'h12345678, 1'b1, 1'b0);
        n_cmp++;
        if (first_n != 11) begin
            n_bad++;
            $display("FAIL first_latency: got %0d cycles, need 11", first_n);
        end
        n_cmp++;
        if (nbytes != 140) begin
            n_bad++;
            $display("FAIL total_bytes: got %0d, need 140", nbytes);
        end
        check_rx("ver_ihl", 0, 8'h45);
        check_rx("tos", 1, 8'h00);
        check_rx("total_len_hi", 2, 8'h00);
        check_rx("total_len_lo", 3, 8'h8C);
        check_rx("csum_hi", 10, 8'h5E);
        check_rx("csum_lo", 11, 8'h38);
        check_rx("udp_len_hi", 24, 8'h00);
        check_rx("udp_len_lo", 25, 8'h78);
        check_rx("marker_pt", 29, 8'h9F);
    endtask

    task automatic test_bit_packing();
        pay_q.delete();
        pay_q.push_back(8'hA5);
        pay_q.push_back(8'hFF);
        run_packet(1, 2, 32'h0000_0001, 1'b0, 1'b0);
        check_rx("pack_byte0", 40, 8'hA5);
        check_rx("pack_byte1", 41, 8'hFF);
    endtask

    task automatic test_backpressure_seq();
        pay_q.delete();
        for (int i = 0; i < 60; i++) pay_q.push_back(8'($urandom));
        run_packet(2, 60, 32'hCAFE_0000, 1'b0, 1'b0);
        check_rx("seq_first_hi", 30, 8'hFF);
        check_rx("seq_first_lo", 31, 8'hFF);
        save_q = rx_q;
        run_packet(2, 60, 32'hCAFE_0000, 1'b0, 1'b1);
        check_rx("seq_wrap_hi", 30, 8'h00);
        check_rx("seq_wrap_lo", 31, 8'h00);
        n_cmp++;
        if (rx_q.size() != save_q.size() || rx_q[40:$] != save_q[40:$]) begin
            n_bad++;
            $display("FAIL bp_payload: got %0d bytes differing from ready run, need %0d identical",
                     rx_q.size(), save_q.size());
        end
    endtask

    task automatic test_error_zero();
        @(negedge clk);
        start_a[0] = 1'b1; len_a[0] = 11'd1461;
        @(negedge clk);
        start_a[0] = 1'b0;
        n_cmp++;
        if (err_a[0] !== 1'b1 || busy_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pulse: got err=%b busy=%b, need 1 0", err_a[0], busy_a[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (err_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: got err=%b busy=%b, need 0 0", err_a[0], busy_a[0]);
        end
        $display("err: len=1461 rejected");
        pay_q.delete();
        run_packet(0, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
        n_cmp++;
        if (nbytes != 40) begin
            n_bad++;
            $display("FAIL zero_len_bytes: got %0d, need 40", nbytes);
        end
        check_rx("zero_udp_hi", 24, 8'h00);
        check_rx("zero_udp_lo", 25, 8'h14);
    endtask

    task automatic test_reset_midpacket();
        @(negedge clk);
        start_a[0] = 1'b1; len_a[0] = 11'd50; ts_a[0] = 32'h1; marker_a[0] = 1'b0;
        @(negedge clk);
        start_a[0] = 1'b0;
        in_valid_a[0] = 1'b1; out_ready_a[0] = 1'b1;
        repeat (60) begin
            in_data_a[0] = 8'($urandom);
            @(negedge clk);
        end
        n_cmp++;
        if (busy_a[0] !== 1'b1 || in_ready_a[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_payload: got busy=%b in_ready=%b, need 1 1", busy_a[0], in_ready_a[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abort: got v=%b ir=%b busy=%b, need 0 0 0",
                     out_valid_a[0], in_ready_a[0], busy_a[0]);
        end
        rst = 1'b0;
        in_valid_a[0] = 1'b0;
        for (int k = 0; k < NDUT; k++) seq_exp[k] = seq_init_of[k];
        $display("reset: applied mid-payload");
        pay_q.delete();
        for (int i = 0; i < 10; i++) pay_q.push_back(8'($urandom));
        run_packet(0, 10, 32'h2, 1'b0, 1'b0);
        check_rx("seq_after_rst_hi", 30, 8'h00);
        check_rx("seq_after_rst_lo", 31, 8'h00);
    endtask

    initial begin
        test_reset();
        test_header();
        test_bit_packing();
        test_backpressure_seq();
        test_error_zero();
        test_reset_midpacket();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, need finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
